// File: rtl/icon_xfer_agent_pkg.sv
// Shared types and defaults for the interconnect operand-transfer agent.
// Address, data and channel types are common to the execution-unit buffers.
package icon_xfer_agent_pkg;

  localparam int unsigned ICON_XFER_FIFO_IDX_BITS = 2;

  typedef struct packed {
    logic [2:0] euidx;
    logic [3:0] uid;
    logic       spec;
  } type_exec_unit_addr;

  typedef logic [15:0] type_exec_unit_data;

  typedef struct packed {
    type_exec_unit_addr addr;
    type_exec_unit_data data;
    logic               valid;
  } type_icon_tx_channel;

  typedef struct packed {
    logic success;
  } type_icon_rx_channel;

  typedef struct packed {
    type_exec_unit_addr addr;
    logic               chan;
  } type_icon_xfer_req;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } type_icon_xfer_state;

  function automatic logic [3:0] wait_inc(input logic [3:0] w);
    return (w == 4'hF) ? w : w + 4'd1;
  endfunction

endpackage

// File: rtl/icon_xfer_agent_req_fifo.sv
// Small synchronous FIFO of transfer requests; the head is visible on rdata_o
// until popped.
module icon_xfer_agent_req_fifo
  import icon_xfer_agent_pkg::*;
#(
  parameter int unsigned IdxBits = ICON_XFER_FIFO_IDX_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  type_icon_xfer_req wdata_i,
  input  logic              pop_i,
  output type_icon_xfer_req rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [IdxBits:0]  count_o
);

  localparam int unsigned Depth = 1 << IdxBits;

  type_icon_xfer_req  mem_q [Depth];
  logic [IdxBits-1:0] wptr_q, rptr_q;
  logic [IdxBits:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o  = count_q[IdxBits];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/icon_xfer_agent.sv
// Moves operands from a producer's outbound buffer into a consumer's op0/op1
// inbound buffer, one queued request at a time, retrying both sides.
module icon_xfer_agent
  import icon_xfer_agent_pkg::*;
#(
  parameter int unsigned REQ_FIFO_IDX_BITS = ICON_XFER_FIFO_IDX_BITS,
  parameter int unsigned STALL_THRESH      = 15
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid_i,
  input  type_exec_unit_addr  req_addr_i,
  input  logic                req_chan_i,
  output logic                req_ready_o,
  input  type_exec_unit_data  src_rdata_i,
  output type_exec_unit_addr  src_raddr_o,
  output logic                src_rvalid_o,
  input  logic                src_rsuccess_i,
  output type_icon_tx_channel dst_w0_o,
  input  type_icon_rx_channel dst_w0_rx_i,
  output type_icon_tx_channel dst_w1_o,
  input  type_icon_rx_channel dst_w1_rx_i,
  output logic                busy_o,
  output logic                stall_o,
  output logic [15:0]         xfer_count_o
);

  type_icon_xfer_state        state_q, state_d;
  logic [3:0]                 wait_q, wait_d;
  type_exec_unit_data         data_q, data_d;
  logic [15:0]                xfer_q, xfer_d;
  type_icon_xfer_req          head;
  logic                       full, empty, push, pop, wr_success;
  logic [REQ_FIFO_IDX_BITS:0] fifo_count;

  assign req_ready_o  = ~full;
  assign push         = req_valid_i & req_ready_o;
  assign wr_success   = head.chan ? dst_w1_rx_i.success : dst_w0_rx_i.success;
  assign busy_o       = (state_q != StIdle) | ~empty;
  assign stall_o      = 32'(wait_q) >= STALL_THRESH;
  assign xfer_count_o = xfer_q;

  icon_xfer_agent_req_fifo #(
    .IdxBits (REQ_FIFO_IDX_BITS)
  ) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .wdata_i ('{addr: req_addr_i, chan: req_chan_i}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    data_d       = data_q;
    xfer_d       = xfer_q;
    pop          = 1'b0;
    src_rvalid_o = 1'b0;
    src_raddr_o  = '0;
    dst_w0_o     = '0;
    dst_w1_o     = '0;
    unique case (state_q)
      StIdle: begin
        if (!empty) state_d = StRead;
      end
      StRead: begin
        src_rvalid_o = 1'b1;
        src_raddr_o  = head.addr;
        if (src_rsuccess_i) begin
          data_d  = src_rdata_i;
          wait_d  = '0;
          state_d = StWrite;
        end else begin
          wait_d = wait_inc(wait_q);
        end
      end
      StWrite: begin
        if (head.chan) begin
          dst_w1_o.valid = 1'b1;
          dst_w1_o.addr  = head.addr;
          dst_w1_o.data  = data_q;
        end else begin
          dst_w0_o.valid = 1'b1;
          dst_w0_o.addr  = head.addr;
          dst_w0_o.data  = data_q;
        end
        if (wr_success) begin
          pop    = 1'b1;
          xfer_d = xfer_q + 16'd1;
          wait_d = '0;
          // Stay busy if anything is left after this pop, counting a same-cycle push.
          state_d = (fifo_count > (REQ_FIFO_IDX_BITS + 1)'(1) || push) ? StRead : StIdle;
        end else begin
          wait_d = wait_inc(wait_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      wait_q  <= '0;
      data_q  <= '0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      xfer_q  <= xfer_d;
    end
  end

endmodule

// File: tb/tb_icon_xfer_agent.sv
// Scoreboard bench for icon_xfer_agent: randomized producer/consumer responders,
// expected transfers queued at request time and checked by an independent monitor.
module tb_icon_xfer_agent;
  import icon_xfer_agent_pkg::*;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                req_valid_i;
  type_exec_unit_addr  req_addr_i;
  logic                req_chan_i;
  logic                req_ready_o;
  type_exec_unit_data  src_rdata_i;
  type_exec_unit_addr  src_raddr_o;
  logic                src_rvalid_o;
  logic                src_rsuccess_i;
  type_icon_tx_channel dst_w0_o, dst_w1_o;
  type_icon_rx_channel dst_w0_rx_i, dst_w1_rx_i;
  logic                busy_o, stall_o;
  logic [15:0]         xfer_count_o;

  always #5 clk = ~clk;

  icon_xfer_agent #(
    .REQ_FIFO_IDX_BITS (2),
    .STALL_THRESH      (15)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .req_chan_i     (req_chan_i),
    .req_ready_o    (req_ready_o),
    .src_rdata_i    (src_rdata_i),
    .src_raddr_o    (src_raddr_o),
    .src_rvalid_o   (src_rvalid_o),
    .src_rsuccess_i (src_rsuccess_i),
    .dst_w0_o       (dst_w0_o),
    .dst_w0_rx_i    (dst_w0_rx_i),
    .dst_w1_o       (dst_w1_o),
    .dst_w1_rx_i    (dst_w1_rx_i),
    .busy_o         (busy_o),
    .stall_o        (stall_o),
    .xfer_count_o   (xfer_count_o)
  );

  typedef struct {
    type_exec_unit_addr addr;
    logic               chan;
    type_exec_unit_data data;
  } exp_t;

  exp_t               sb_q[$];
  int                 done_cycles[$];
  type_exec_unit_data src_mem [256];
  int n_checks = 0;
  int n_fail = 0;
  int rd_pct = 100;
  int wr_pct = 100;
  int rd_fail_left = 0;
  int wr_fail_left = 0;
  int cyc = 0;
  int last_rd_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Producer/consumer responders: success is random even when valid is low.
  always @(negedge clk) begin
    if (src_rvalid_o && rd_fail_left > 0) begin
      src_rsuccess_i = 1'b0;
      rd_fail_left--;
    end else begin
      src_rsuccess_i = ($urandom_range(99) < rd_pct);
    end
    src_rdata_i = src_rsuccess_i ? src_mem[src_raddr_o] : 16'($urandom);
    if ((dst_w0_o.valid || dst_w1_o.valid) && wr_fail_left > 0) begin
      dst_w0_rx_i.success = 1'b0;
      dst_w1_rx_i.success = 1'b0;
      wr_fail_left--;
    end else begin
      dst_w0_rx_i.success = ($urandom_range(99) < wr_pct);
      dst_w1_rx_i.success = ($urandom_range(99) < wr_pct);
    end
  end

  // Monitor: compares DUT outputs against the queued transfers and the rules.
  int                  fail_run = 0;
  int                  rd_run = 0;
  logic [15:0]         xfer_model = '0;
  logic                prev_rd_fail = 1'b0, prev_wr_fail = 1'b0;
  type_exec_unit_addr  prev_raddr;
  logic [49:0]         prev_tx;

  always @(negedge clk) begin
    type_icon_tx_channel tx;
    logic wvalid, wsucc, rd_fail, rd_ok, wr_fail, wr_done;
    #2;
    if (!reset_n) begin
      fail_run     = 0;
      rd_run       = 0;
      xfer_model   = '0;
      prev_rd_fail = 1'b0;
      prev_wr_fail = 1'b0;
    end else begin
      wvalid = dst_w0_o.valid | dst_w1_o.valid;
      check("busy", busy_o, sb_q.size() != 0);
      check("ready", req_ready_o, sb_q.size() < 4);
      check("xfer_count", xfer_count_o, xfer_model);
      check("stall", stall_o, fail_run >= 15);
      check("both_valid", dst_w0_o.valid & dst_w1_o.valid, 1'b0);
      if (src_rvalid_o) begin
        if (sb_q.size() == 0) check("read_no_req", sb_q.size(), 1);
        else check("raddr", src_raddr_o, sb_q[0].addr);
      end else begin
        check("raddr_idle", src_raddr_o, 0);
      end
      if (prev_rd_fail) begin
        check("rd_hold_valid", src_rvalid_o, 1'b1);
        check("rd_hold_addr", src_raddr_o, prev_raddr);
      end
      tx = dst_w1_o.valid ? dst_w1_o : dst_w0_o;
      if (wvalid) begin
        if (sb_q.size() == 0) begin
          check("write_no_req", sb_q.size(), 1);
        end else begin
          check("w_chan", dst_w1_o.valid, sb_q[0].chan);
          check("w_addr", tx.addr, sb_q[0].addr);
          check("w_data", tx.data, sb_q[0].data);
        end
      end
      if (!dst_w0_o.valid) check("w0_idle", {dst_w0_o.addr, dst_w0_o.data}, 0);
      if (!dst_w1_o.valid) check("w1_idle", {dst_w1_o.addr, dst_w1_o.data}, 0);
      if (prev_wr_fail) check("w_hold", {dst_w0_o, dst_w1_o}, prev_tx);

      wsucc   = dst_w1_o.valid ? dst_w1_rx_i.success : dst_w0_rx_i.success;
      rd_fail = src_rvalid_o & ~src_rsuccess_i;
      rd_ok   = src_rvalid_o & src_rsuccess_i;
      wr_fail = wvalid & ~wsucc;
      wr_done = wvalid & wsucc;
      if (rd_fail || wr_fail) fail_run = (fail_run < 15) ? fail_run + 1 : 15;
      else if (rd_ok || wr_done) fail_run = 0;
      if (src_rvalid_o) rd_run++;
      if (rd_ok) begin
        last_rd_len = rd_run;
        rd_run      = 0;
      end
      if (wr_done && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
        xfer_model = xfer_model + 16'd1;
        done_cycles.push_back(cyc);
      end
      prev_rd_fail = rd_fail;
      prev_wr_fail = wr_fail;
      prev_raddr   = src_raddr_o;
      prev_tx      = {dst_w0_o, dst_w1_o};
    end
  end

  task automatic push_req(input type_exec_unit_addr a, input logic ch);
    int t = 0;
    @(negedge clk);
    while (!req_ready_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready_o) begin
      check("push_timeout", req_ready_o, 1'b1);
      return;
    end
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_chan_i  = ch;
    @(posedge clk);
    sb_q.push_back('{addr: a, chan: ch, data: src_mem[a]});
    #1 req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || busy_o) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    type_exec_unit_addr a;
    logic [15:0] base;
    for (int i = 0; i < 256; i++) src_mem[i] = 16'($urandom);
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_chan_i  = 1'b0;
    reset_n     = 1'b1;
    #1 reset_n  = 1'b0;
    #2;
    check("rst_ready", req_ready_o, 1'b1);
    check("rst_outs", {src_rvalid_o, src_raddr_o, dst_w0_o, dst_w1_o, busy_o, stall_o}, 0);
    check("rst_count", xfer_count_o, 0);
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;

    // Single transfer on op0.
    a = '{euidx: 3'd1, uid: 4'd5, spec: 1'b0};
    src_mem[a] = 16'hA5A5;
    push_req(a, 1'b0);
    drain();
    check("single_count", xfer_count_o, 1);

    // Read retry: three misses then a hit, delivered on op1.
    a = '{euidx: 3'd2, uid: 4'd9, spec: 1'b1};
    src_mem[a] = 16'h1234;
    rd_fail_left = 3;
    push_req(a, 1'b1);
    drain();
    check("rd_retry_len", last_rd_len, 4);

    // Write backpressure long enough to saturate the stall counter.
    wr_fail_left = 20;
    push_req('{euidx: 3'd3, uid: 4'd1, spec: 1'b0}, 1'b0);
    repeat (18) @(negedge clk);
    #3 check("stall_high", stall_o, 1'b1);
    drain();
    check("stall_clear", stall_o, 1'b0);

    // FIFO fills with the write side blocked; order is checked on release.
    wr_fail_left = 100000;
    for (int i = 1; i <= 4; i++) push_req('{euidx: 3'd2, uid: 4'(i), spec: 1'b0}, 1'($urandom));
    repeat (2) @(negedge clk);
    #3 check("full_ready", req_ready_o, 1'b0);
    @(posedge clk);
    #1 wr_fail_left = 0;
    drain();

    // Back-to-back: four queued, everything succeeds -> one write every 2 cycles.
    wr_fail_left = 100000;
    for (int i = 0; i < 4; i++) push_req(8'($urandom), 1'($urandom));
    repeat (2) @(negedge clk);
    base = xfer_count_o;
    done_cycles.delete();
    @(posedge clk);
    #1 wr_fail_left = 0;
    drain();
    check("b2b_count", xfer_count_o - base, 4);
    check("b2b_writes", done_cycles.size(), 4);
    for (int i = 1; i < done_cycles.size(); i++)
      check("b2b_gap", done_cycles[i] - done_cycles[i-1], 2);

    // Randomized traffic with random success on both sides.
    rd_pct = 70;
    wr_pct = 70;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(2)) @(negedge clk);
      push_req(8'($urandom), 1'($urandom));
    end
    drain();
    rd_pct = 100;
    wr_pct = 100;

    // Reset mid-WRITE with two more requests queued behind the head.
    wr_fail_left = 100000;
    for (int i = 0; i < 3; i++) push_req(8'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 reset_n = 1'b0;
    sb_q.delete();
    wr_fail_left = 0;
    #1;
    check("mid_rst_outs", {src_rvalid_o, src_raddr_o, dst_w0_o, dst_w1_o, busy_o, stall_o}, 0);
    check("mid_rst_ready", req_ready_o, 1'b1);
    check("mid_rst_count", xfer_count_o, 0);
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (10) @(negedge clk);
    #3 check("post_rst_count", xfer_count_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icon_xfer_agent.md
Name: icon_xfer_agent

Overview:
- Interconnect-side counterpart of an execution unit's operand buffers.
- Dequeues operand-transfer requests and reads the operand out of a producer EU's outbound (tx) buffer through its read port (raddr/rvalid/rdata/rsuccess).
- Writes the operand into a consumer EU's inbound buffer on the op0 or op1 write channel (addr/data/valid to success).
- One instance serves one producer-to-consumer link; retries on both sides until the transfer succeeds.

Parameters:
- REQ_FIFO_IDX_BITS, 2, log2 of request FIFO depth (depth = 4).
- STALL_THRESH, 15, consecutive failed read or write cycles before stall_o asserts; 4-bit counter, saturating.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req_valid_i  in  1  transfer request valid
- req_addr_i  in  type_exec_unit_addr  operand address (euidx, uid, spec)
- req_chan_i  in  1  destination channel: 0 = w0/op0, 1 = w1/op1
- req_ready_o  out  1  FIFO not full
- src_rdata_i  in  type_exec_unit_data  producer read data
- src_raddr_o  out  type_exec_unit_addr  producer read address
- src_rvalid_o  out  1  producer read request
- src_rsuccess_i  in  1  producer read hit, same cycle as src_rvalid_o
- dst_w0_o  out  type_icon_tx_channel  op0 write channel (addr, data, valid)
- dst_w0_rx_i  in  type_icon_rx_channel  op0 write success
- dst_w1_o  out  type_icon_tx_channel  op1 write channel
- dst_w1_rx_i  in  type_icon_rx_channel  op1 write success
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- stall_o  out  1  wait counter ≥ STALL_THRESH
- xfer_count_o  out  16  completed transfers, wraps modulo 2^16

Behaviour:
- Reset (async, reset_n low), all outputs 0 except req_ready_o = 1:
  - FIFO empty; FSM IDLE; wait counter 0; xfer_count_o 0; latched data 0.
  - A reset mid-transfer discards the in-flight request and all queued requests. No write valid is held across reset.
- Push: req_valid_i & req_ready_o stores {addr, chan}. req_ready_o = ~full, registered from the FIFO count; there is no pop-to-push bypass. A push while full is ignored; the bench must not issue one.
- FSM states:
  - IDLE:
    - FIFO non-empty -> READ (the head is visible; no pop yet).
  - READ:
    - src_rvalid_o = 1 and src_raddr_o = head addr, combinationally.
    - src_rsuccess_i = 1: latch src_rdata_i and reset the wait counter -> WRITE.
    - Otherwise: stay in READ and increment the wait counter.
  - WRITE:
    - Drive dst_w{chan}_o.valid = 1 with head addr and latched data. The other channel's valid = 0.
    - Matching rx success = 1: pop the FIFO, increment xfer_count_o, reset the wait counter. Go to READ if at least 2 entries remain before the pop (or a push lands this cycle while 1 remains); otherwise go to IDLE.
    - Otherwise: hold addr/data/valid stable and increment the wait counter.
- Timing: minimum transfer = 2 cycles after the request reaches the head (1 read, 1 write). Back-to-back transfers sustain 1 per 2 cycles.
- Outside READ, src_rvalid_o = 0 and src_raddr_o = 0. Outside WRITE, both write valids = 0 and addr/data = 0.
- Success inputs are ignored when the corresponding valid is low.
- Wait counter saturates at 15; stall_o is combinational from the counter. Reaching the threshold has no functional effect: retries continue indefinitely.
- Ordering: strictly FIFO. A failed head blocks later requests (no reordering).
- Simultaneous push and pop in the same cycle is legal; the count is unchanged.

Decomposition:
- pkg_dtypes:
  - type_icon_xfer_req {type_exec_unit_addr addr; logic chan;}
  - enum type_icon_xfer_state {IDLE, READ, WRITE}
  - Existing type_exec_unit_addr, type_exec_unit_data, type_icon_tx_channel, type_icon_rx_channel are reused.
- Default FIFO depth constant ICON_XFER_FIFO_IDX_BITS in design_parameters.sv.
- Sub-module icon_req_fifo:
  - Parameterised synchronous FIFO of type_icon_xfer_req with push/pop/full/empty/count.
  - Pointers wrap at depth.

Test Plan:
- Single transfer, chan 0, addr {euidx=1, uid=5, spec=0}, src_rsuccess_i tied 1, data 0xA5A5 -> dst_w0 valid one cycle with that addr/data, success=1; xfer_count_o = 1; dst_w1 never valid.
- Read retry: src_rsuccess_i low for 3 cycles, then high with 0x1234 -> src_rvalid_o high 4 consecutive cycles with a constant address, then dst_w1 write of 0x1234 when chan = 1.
- Write backpressure: dst_w0_rx_i.success low 20 cycles -> addr/data/valid held constant; stall_o rises after 15 failed cycles; clears after success.
- FIFO full/ordering: push 5 requests (uids 1–5) while the write side is blocked -> req_ready_o drops after 4 accepted and the 5th is not pushed; on release, writes occur in order uid 1, 2, 3, 4.
- Back-to-back: 4 queued requests with both sides always succeeding -> a write every 2nd cycle; xfer_count_o = 4 after 8 cycles; busy_o falls the cycle after the last pop.
- Reset mid-WRITE with 2 queued requests -> all outputs 0 immediately; req_ready_o = 1, FIFO empty, xfer_count_o = 0; no write valid after reset release.
